// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: round-robin share of one signed saturating adder among
// N_REQ requesters. Results go out through a one-entry response register
// with valid/ready. A sticky counter tracks saturated transactions.
module sat_add_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_sat,
  input  logic                 sat_clr,
  output logic [CNT_W-1:0]     sat_cnt
);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_sat_q, rsp_sat_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic             stage_free;
  logic             gnt_any;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W:0]    idx_w;
  logic             xfer;
  logic [W-1:0]     op_a, op_b, sum_w, sat_val;
  logic             ovf;

  assign stage_free = !rsp_valid_q || rsp_ready;
  assign xfer       = stage_free && gnt_any;

  // Rotating priority search: first valid requester at or after rr_ptr.
  // The extra index bit lets the wrap work for non-power-of-two N_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_w   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx_w >= (ID_W+1)'(N_REQ)) idx_w = idx_w - (ID_W+1)'(N_REQ);
      if (!gnt_any && req_valid[idx_w[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w[ID_W-1:0];
      end
    end
  end

  // One-hot accept, only when the response register can take the result.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = xfer && (gnt_idx == ID_W'(i));
  end

  // Operand mux for the granted requester.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        op_a = req_a[i*W +: W];
        op_b = req_b[i*W +: W];
      end
    end
  end

  // Wrapped sum, clamped on signed overflow toward the operands' sign.
  always_comb begin
    sum_w   = op_a + op_b;
    ovf     = (op_a[W-1] == op_b[W-1]) && (sum_w[W-1] != op_a[W-1]);
    sat_val = sum_w;
    if (ovf) sat_val = op_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // Response register, round-robin pointer and saturation counter next state.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_sat_d   = rsp_sat_q;
    rr_ptr_d    = rr_ptr_q;
    sat_cnt_d   = sat_cnt_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sat_val;
      rsp_id_d    = gnt_idx;
      rsp_sat_d   = ovf;
      rr_ptr_d    = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    // Clear beats a same-cycle increment; counter sticks at all-ones.
    if (sat_clr)
      sat_cnt_d = '0;
    else if (xfer && ovf && !(&sat_cnt_q))
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
  end

  // State registers, async cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_sat_q   <= 1'b0;
      rr_ptr_q    <= '0;
      sat_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sat_q   <= rsp_sat_d;
      rr_ptr_q    <= rr_ptr_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sat   = rsp_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Directed bench for sat_add_arbiter: main instance (4x8, 16-bit counter)
// plus a 2-bit-counter instance for counter stick-at-max.
module tb_sat_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_sat, sat_clr;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] sat_cnt;

  logic [3:0]  s_valid, s_ready;
  logic [31:0] s_a, s_b;
  logic        s_rvalid, s_rready, s_rsat, s_clr;
  logic [7:0]  s_data;
  logic [1:0]  s_id;
  logic [1:0]  s_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  sat_add_arbiter #(.N_REQ(4), .W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_sat(rsp_sat),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  sat_add_arbiter #(.N_REQ(4), .W(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_ready(s_ready),
    .req_a(s_a), .req_b(s_b), .rsp_valid(s_rvalid), .rsp_ready(s_rready),
    .rsp_data(s_data), .rsp_id(s_id), .rsp_sat(s_rsat),
    .sat_clr(s_clr), .sat_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] d, input logic sat);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_data"},  32'(rsp_data),  32'(d));
    chk({tag, "_sat"},   32'(rsp_sat),   32'(sat));
  endtask

  initial begin
    logic [1:0] exp_id;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; sat_clr = 1'b0;
    s_valid = '0; s_a = '0; s_b = '0; s_rready = 1'b0; s_clr = 1'b0;
    #2;
    // Reset state
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data",  32'(rsp_data),  0);
    chk("rst_id",    32'(rsp_id),    0);
    chk("rst_sat",   32'(rsp_sat),   0);
    chk("rst_cnt",   32'(sat_cnt),   0);
    chk("rst_ready", 32'(req_ready), 0);
    #10 rst_n = 1'b1;

    // Single request from requester 2
    req_valid = 4'b0100; req_a[23:16] = 8'h30; req_b[23:16] = 8'h20; rsp_ready = 1'b1;
    #1 chk("r2_ready", 32'(req_ready), 32'h4);
    tick();
    chk_rsp("r2", 2'd2, 8'h50, 1'b0);
    req_valid = '0;

    // Saturation cases on requester 0 (pointer now 3, wraps to 0)
    req_valid = 4'b0001; req_a[7:0] = 8'h70; req_b[7:0] = 8'h20;
    tick();
    chk_rsp("pos_sat", 2'd0, 8'h7F, 1'b1);
    req_a[7:0] = 8'h80; req_b[7:0] = 8'hFF;
    tick();
    chk_rsp("neg_sat", 2'd0, 8'h80, 1'b1);
    req_a[7:0] = 8'h7F; req_b[7:0] = 8'h81;
    tick();
    chk_rsp("no_sat", 2'd0, 8'h00, 1'b0);
    req_valid = '0;
    tick();
    chk("drained", 32'(rsp_valid), 0);
    chk("cnt2",    32'(sat_cnt),   2);

    // All valid, continuous drain: pointer is 1 so order is 1,2,3,0,...
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(i + 1);
      req_b[i*8 +: 8] = 8'h10;
    end
    req_valid = 4'b1111;
    #1 chk("rr_first_ready", 32'(req_ready), 32'h2);
    exp_id = 2'd1;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk_rsp($sformatf("rr%0d", n), exp_id, 8'h11 + 8'(exp_id), 1'b0);
      exp_id = exp_id + 2'd1;
    end

    // Backpressure: hold requester 0's result for 5 cycles
    rsp_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1 chk($sformatf("bp_ready%0d", n), 32'(req_ready), 0);
      tick();
      chk_rsp($sformatf("bp%0d", n), 2'd0, 8'h11, 1'b0);
    end
    rsp_ready = 1'b1;
    #1 chk("rel_ready", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("rel", 2'd1, 8'h12, 1'b0);

    // Three saturating transfers, clear on the third
    req_valid = 4'b1000; req_a[31:24] = 8'h7F; req_b[31:24] = 8'h01;
    tick();
    chk("clr_c1", 32'(sat_cnt), 3);
    tick();
    chk("clr_c2", 32'(sat_cnt), 4);
    sat_clr = 1'b1;
    tick();
    chk("clr_sat", 32'(rsp_sat), 1);
    chk("clr_cnt", 32'(sat_cnt), 0);
    sat_clr = 1'b0; req_valid = '0;
    tick();

    // Reset mid-operation with a pending response and nonzero pointer
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'h70;
      req_b[i*8 +: 8] = 8'h20;
    end
    req_valid = 4'b1111;
    tick();
    chk_rsp("pre_rst0", 2'd0, 8'h7F, 1'b1);
    tick();
    chk_rsp("pre_rst1", 2'd1, 8'h7F, 1'b1);
    chk("pre_rst_cnt", 32'(sat_cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_cnt",   32'(sat_cnt),   0);
    #2 rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("post_rst", 2'd0, 8'h7F, 1'b1);
    req_valid = '0;

    // 2-bit counter sticks at 3
    s_valid = 4'b0001; s_a[7:0] = 8'h70; s_b[7:0] = 8'h20; s_rready = 1'b1;
    tick(); tick(); tick();
    chk("small_cnt3", 32'(s_cnt), 3);
    tick(); tick();
    chk("small_cnt5", 32'(s_cnt), 3);
    chk("small_sat",  32'(s_rsat), 1);
    s_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
